// File: rtl/jump_physics.sv
// jump_physics: vertical jump engine for the player sprite.
// A grounded/rising/falling state machine advances player_y and the speed
// magnitude once per rising edge of the can_jump strobe. The jump button is
// synchronised, edge-detected and latched as a launch request while grounded.
module jump_physics #(
    parameter int Y_WIDTH  = 10,
    parameter int GROUND_Y = 400,
    parameter int JUMP_VEL = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 12
) (
    input  logic               proc_clk,
    input  logic               reset,
    input  logic               can_jump,
    input  logic               jump_btn,
    output logic [Y_WIDTH-1:0] player_y,
    output logic [7:0]         velocity,
    output logic [1:0]         state,
    output logic               in_air,
    output logic               landed
);

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } state_e;

    // Comparison width: wide enough for both y and speed plus a carry bit,
    // so y + speed never wraps before the ground test.
    localparam int CW = ((Y_WIDTH > 8) ? Y_WIDTH : 8) + 1;

    localparam logic [Y_WIDTH-1:0] GROUND_YV = Y_WIDTH'(GROUND_Y);
    localparam logic [CW-1:0]      GROUND_CW = CW'(GROUND_Y);
    localparam logic [7:0]         JUMP_V8   = 8'(JUMP_VEL);
    localparam logic [7:0]         GRAV8     = 8'(GRAVITY);
    localparam logic [7:0]         MAXF8     = 8'(MAX_FALL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               cj_q;
    logic               btn_s1_q, btn_s2_q, btn_s3_q;
    logic               req_q, req_d;
    state_e             state_q, state_d;
    logic [Y_WIDTH-1:0] y_q, y_d;
    logic [7:0]         vel_q, vel_d;
    logic               landed_q, landed_d;

    logic               tick;
    logic               press;

    // Datapath intermediates for the rise/fall arithmetic
    logic [CW-1:0]      y_ext;
    logic [CW-1:0]      v_ext;
    logic [CW-1:0]      rise_diff;
    logic [8:0]         v_sum;
    logic [7:0]         v_n;
    logic [CW-1:0]      fall_sum;

    // One update per strobe, however long can_jump stays high.
    assign tick  = can_jump & ~cj_q;
    // Rising edge of the synchronised button; a held button presses once.
    assign press = btn_s2_q & ~btn_s3_q;

    // Strobe edge-detect register
    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) cj_q <= 1'b0;
        else       cj_q <= can_jump;
    end

    // Two-flop synchroniser for the asynchronous button, plus an edge-detect stage
    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            btn_s3_q <= 1'b0;
        end else begin
            btn_s1_q <= jump_btn;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
        end
    end

    // Launch request: a grounded press sets it (winning over a same-edge tick,
    // so the request survives to the next tick); any other tick consumes it.
    // Presses while airborne never set it.
    always_comb begin
        req_d = req_q;
        if (press && (state_q == GROUNDED)) req_d = 1'b1;
        else if (tick)                      req_d = 1'b0;
    end

    // Request latch
    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) req_q <= 1'b0;
        else       req_q <= req_d;
    end

    // Arithmetic shared by the next-state logic
    always_comb begin
        y_ext     = CW'(y_q);
        v_ext     = CW'(vel_q);
        rise_diff = y_ext - v_ext;
        v_sum     = {1'b0, vel_q} + {1'b0, GRAV8};
        v_n       = (v_sum > {1'b0, MAXF8}) ? MAXF8 : v_sum[7:0];
        fall_sum  = y_ext + CW'(v_n);
    end

    // Next-state and next-output logic; everything holds between ticks
    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        vel_d    = vel_q;
        landed_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                GROUNDED: begin
                    // The launch tick only loads speed; y moves from the next tick.
                    if (req_q) begin
                        vel_d   = JUMP_V8;
                        state_d = RISING;
                    end
                end
                RISING: begin
                    if (y_ext < v_ext) begin
                        // Would pass the top of the screen: clamp to 0 and start falling.
                        y_d     = '0;
                        vel_d   = '0;
                        state_d = FALLING;
                    end else if (vel_q <= GRAV8) begin
                        // Last upward step: apex reached.
                        y_d     = Y_WIDTH'(rise_diff);
                        vel_d   = '0;
                        state_d = FALLING;
                    end else begin
                        y_d     = Y_WIDTH'(rise_diff);
                        vel_d   = vel_q - GRAV8;
                    end
                end
                FALLING: begin
                    if (fall_sum >= GROUND_CW) begin
                        y_d      = GROUND_YV;
                        vel_d    = '0;
                        state_d  = GROUNDED;
                        landed_d = 1'b1;
                    end else begin
                        y_d      = Y_WIDTH'(fall_sum);
                        vel_d    = v_n;
                    end
                end
                default: begin
                    // Unused encoding: recover to a clean grounded state.
                    y_d     = GROUND_YV;
                    vel_d   = '0;
                    state_d = GROUNDED;
                end
            endcase
        end
    end

    // Physics state registers; reset snaps the player to the ground at once
    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) begin
            state_q  <= GROUNDED;
            y_q      <= GROUND_YV;
            vel_q    <= '0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            vel_q    <= vel_d;
            landed_q <= landed_d;
        end
    end

    assign player_y = y_q;
    assign velocity = vel_q;
    assign state    = state_q;
    assign in_air   = (state_q != GROUNDED);
    assign landed   = landed_q;

endmodule
